// File: rtl/ga_alu_arbiter_pkg.sv
// Shared types for the GA ALU arbiter: multivector layout, ALU function codes,
// arbiter error causes, arbiter FSM states and the supported-funct screen.
package ga_alu_arbiter_pkg;

    // 3D geometric-algebra multivector, one signed 16-bit lane per blade
    typedef struct packed {
        logic signed [15:0] scalar;
        logic signed [15:0] e1;
        logic signed [15:0] e2;
        logic signed [15:0] e3;
        logic signed [15:0] e12;
        logic signed [15:0] e23;
        logic signed [15:0] e31;
        logic signed [15:0] e123;
    } ga_multivector_t;

    typedef enum logic [3:0] {
        GA_FUNCT_ADD     = 4'd0,
        GA_FUNCT_SUB     = 4'd1,
        GA_FUNCT_MUL     = 4'd2,
        GA_FUNCT_WEDGE   = 4'd3,
        GA_FUNCT_DOT     = 4'd4,
        GA_FUNCT_DUAL    = 4'd5,
        GA_FUNCT_REV     = 4'd6,
        GA_FUNCT_NORM    = 4'd7,
        GA_FUNCT_ROTATE  = 4'd8,
        GA_FUNCT_REFLECT = 4'd9
    } ga_funct_e;

    typedef enum logic [1:0] {
        GA_ARB_ERR_NONE    = 2'd0,
        GA_ARB_ERR_ALU     = 2'd1,
        GA_ARB_ERR_ILLEGAL = 2'd2,
        GA_ARB_ERR_TIMEOUT = 2'd3
    } ga_arb_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ga_arb_state_e;

    // Encodings outside the list never reach the ALU
    function automatic logic ga_funct_supported(ga_funct_e f);
        case (f)
            GA_FUNCT_ADD, GA_FUNCT_SUB, GA_FUNCT_MUL, GA_FUNCT_WEDGE,
            GA_FUNCT_DOT, GA_FUNCT_DUAL, GA_FUNCT_REV, GA_FUNCT_NORM,
            GA_FUNCT_ROTATE, GA_FUNCT_REFLECT: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ga_alu_arbiter_rr_pick.sv
// Circular priority picker: first set request at or after ptr_i, wrapping.
module ga_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW:0]   w_sum;
    logic [IdxW-1:0] w_pos;

    // Scan NumReq positions starting at the pointer, keep the first hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_sum = {1'b0, ptr_i} + (IdxW+1)'(k);
            if (w_sum >= (IdxW+1)'(NumReq)) begin
                w_sum = w_sum - (IdxW+1)'(NumReq);
            end
            w_pos = w_sum[IdxW-1:0];
            if (!valid_o && req_i[w_pos]) begin
                valid_o        = 1'b1;
                grant_o[w_pos] = 1'b1;
                idx_o          = w_pos;
            end
        end
    end

endmodule

// File: rtl/ga_alu_arbiter.sv
// Shares one ga_alu between NumReq requesters: round-robin grant, operand
// latching, clean-idle issue handshake, WAIT timeout and a held response.
module ga_alu_arbiter
    import ga_alu_arbiter_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  ga_multivector_t     req_op_a_i  [NumReq],
    input  ga_multivector_t     req_op_b_i  [NumReq],
    input  ga_funct_e           req_funct_i [NumReq],
    output logic [NumReq-1:0]   rsp_valid_o,
    input  logic [NumReq-1:0]   rsp_ready_i,
    output ga_multivector_t     rsp_result_o,
    output ga_arb_err_e         rsp_err_o,
    output ga_multivector_t     alu_operand_a_o,
    output ga_multivector_t     alu_operand_b_o,
    output ga_funct_e           alu_operation_o,
    output logic                alu_valid_o,
    input  logic                alu_ready_i,
    input  ga_multivector_t     alu_result_i,
    input  logic                alu_error_i,
    output logic                busy_o
);

    localparam int unsigned IdxW    = $clog2(NumReq);
    localparam int unsigned CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned TmoLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    ga_arb_state_e   r_state;
    logic [IdxW-1:0] r_rr;
    logic [IdxW-1:0] r_gnt_idx;
    ga_multivector_t r_op_a;
    ga_multivector_t r_op_b;
    ga_funct_e       r_funct;
    ga_multivector_t r_result;
    ga_arb_err_e     r_err;
    logic            r_alu_ready_q;
    logic [CntW-1:0] r_tmo_cnt;
    logic            r_alu_valid;
    logic [NumReq-1:0] r_rsp_valid;

    logic [NumReq-1:0] w_grant;
    logic [IdxW-1:0]   w_gnt_idx;
    logic              w_any;
    logic              w_alu_clean;
    logic [NumReq-1:0] w_gnt_onehot;
    logic [IdxW-1:0]   w_rr_next;

    ga_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (r_rr),
        .grant_o (w_grant),
        .idx_o   (w_gnt_idx),
        .valid_o (w_any)
    );

    // ready high in the DONE cycle follows a COMPUTE (ready low), so requiring
    // two consecutive ready cycles rejects a stale DONE left over by a timeout
    assign w_alu_clean  = alu_ready_i && r_alu_ready_q;
    assign w_gnt_onehot = NumReq'(1) << r_gnt_idx;
    assign w_rr_next    = (r_gnt_idx == IdxW'(NumReq - 1)) ? '0 : r_gnt_idx + IdxW'(1);

    // Same-cycle accept strobe to the winning requester while idle
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && r_state == ST_IDLE) begin
            req_ready_o = w_grant;
        end
    end

    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_result_o    = r_result;
    assign rsp_err_o       = r_err;
    assign alu_operand_a_o = r_op_a;
    assign alu_operand_b_o = r_op_b;
    assign alu_operation_o = r_funct;
    assign alu_valid_o     = r_alu_valid;
    assign busy_o          = (r_state != ST_IDLE);

    // Arbiter FSM with registered ALU-side and response-side outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_rr          <= '0;
            r_gnt_idx     <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_funct       <= GA_FUNCT_ADD;
            r_result      <= '0;
            r_err         <= GA_ARB_ERR_NONE;
            r_alu_ready_q <= 1'b0;
            r_tmo_cnt     <= '0;
            r_alu_valid   <= 1'b0;
            r_rsp_valid   <= '0;
        end else begin
            r_alu_ready_q <= alu_ready_i;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_op_a    <= req_op_a_i[w_gnt_idx];
                        r_op_b    <= req_op_b_i[w_gnt_idx];
                        r_funct   <= req_funct_i[w_gnt_idx];
                        if (!ga_funct_supported(req_funct_i[w_gnt_idx])) begin
                            r_result    <= '0;
                            r_err       <= GA_ARB_ERR_ILLEGAL;
                            r_rsp_valid <= w_grant;
                            r_state     <= ST_RESP;
                        end else begin
                            r_alu_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_alu_clean) begin
                        r_alu_valid <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + CntW'(1);
                    if (alu_ready_i) begin
                        r_result    <= alu_result_i;
                        r_err       <= alu_error_i ? GA_ARB_ERR_ALU : GA_ARB_ERR_NONE;
                        r_rsp_valid <= w_gnt_onehot;
                        r_state     <= ST_RESP;
                    end else if (TimeoutCycles != 0 && r_tmo_cnt == CntW'(TmoLast)) begin
                        r_result    <= '0;
                        r_err       <= GA_ARB_ERR_TIMEOUT;
                        r_rsp_valid <= w_gnt_onehot;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[r_gnt_idx]) begin
                        r_rsp_valid <= '0;
                        r_rr        <= w_rr_next;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_alu_arbiter.sv
// Directed bench for ga_alu_arbiter with a behavioural multi-cycle ALU and a
// scoreboard of expected responses pushed at accept time.
module tb_ga_alu_arbiter;
    import ga_alu_arbiter_pkg::*;

    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    ga_multivector_t op_a [2];
    ga_multivector_t op_b [2];
    ga_funct_e       funct [2];
    ga_multivector_t rsp_result, alu_a, alu_b, alu_result;
    ga_arb_err_e     rsp_err;
    ga_funct_e       alu_op;
    logic            alu_valid, alu_ready, alu_error, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed { ga_multivector_t res; logic err; } alu_out_t;
    typedef struct { int idx; ga_multivector_t res; ga_arb_err_e err; } exp_t;
    exp_t sb [$];

    int alu_st  = 0;
    int alu_cnt = 0;
    int alu_lat = 1;

    always #5 clk = ~clk;

    ga_alu_arbiter #(.NumReq(2), .TimeoutCycles(TMO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_a_i      (op_a),
        .req_op_b_i      (op_b),
        .req_funct_i     (funct),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_err_o       (rsp_err),
        .alu_operand_a_o (alu_a),
        .alu_operand_b_o (alu_b),
        .alu_operation_o (alu_op),
        .alu_valid_o     (alu_valid),
        .alu_ready_i     (alu_ready),
        .alu_result_i    (alu_result),
        .alu_error_i     (alu_error),
        .busy_o          (busy)
    );

    function automatic ga_multivector_t sc(int v);
        ga_multivector_t m;
        m = '0;
        m.scalar = 16'(v);
        return m;
    endfunction

    // Behavioural ALU arithmetic (operands in this bench are scalar-only for MUL/NORM)
    function automatic alu_out_t alu_calc(ga_funct_e f, ga_multivector_t a, ga_multivector_t b);
        logic [7:0][15:0] la, lb, lr;
        alu_out_t o;
        la = a; lb = b; lr = la;
        o.err = 1'b0;
        case (f)
            GA_FUNCT_ADD: for (int i = 0; i < 8; i++) lr[i] = la[i] + lb[i];
            GA_FUNCT_SUB: for (int i = 0; i < 8; i++) lr[i] = la[i] - lb[i];
            default: ;
        endcase
        o.res = lr;
        if (f == GA_FUNCT_MUL) begin
            o.res = '0;
            o.res.scalar = 16'(a.scalar * b.scalar);
        end else if (f == GA_FUNCT_NORM) begin
            o.res = '0;
            o.res.scalar = 16'(a.scalar * a.scalar);
            o.err = (a == '0);
        end
        return o;
    endfunction

    function automatic exp_t predict(int idx, ga_funct_e f, ga_multivector_t a, ga_multivector_t b);
        exp_t e;
        alu_out_t o;
        e.idx = idx;
        if (4'(f) > 4'd9) begin
            e.res = '0; e.err = GA_ARB_ERR_ILLEGAL;
        end else if (alu_lat + 1 > TMO) begin
            e.res = '0; e.err = GA_ARB_ERR_TIMEOUT;
        end else begin
            o = alu_calc(f, a, b);
            e.res = o.res;
            e.err = o.err ? GA_ARB_ERR_ALU : GA_ARB_ERR_NONE;
        end
        return e;
    endfunction

    task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU model: IDLE -> COMPUTE (alu_lat cycles, ready low) -> DONE (one cycle) -> IDLE
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_st     <= 0;
            alu_cnt    <= 0;
            alu_result <= '0;
            alu_error  <= 1'b0;
        end else begin
            case (alu_st)
                0: if (alu_valid) begin
                    {alu_result, alu_error} <= alu_calc(alu_op, alu_a, alu_b);
                    alu_cnt <= alu_lat;
                    alu_st  <= 1;
                end
                1: if (alu_cnt <= 1) alu_st <= 2; else alu_cnt <= alu_cnt - 1;
                default: alu_st <= 0;
            endcase
        end
    end
    assign alu_ready = (alu_st != 1);

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back(predict(i, funct[i], op_a[i], op_b[i]));
            end
            if (|(rsp_valid & rsp_ready)) begin
                check("sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_rsp_idx", rsp_valid, 1 << e.idx);
                    check("sb_result", rsp_result, e.res);
                    check("sb_err", rsp_err, e.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = '0; op_b[i] = '0; funct[i] = GA_FUNCT_ADD;
        end
        repeat (2) smp();
        check("rst_ctrl", {req_ready, rsp_valid, alu_valid, busy}, 0);
        check("rst_rsp", {rsp_result, rsp_err}, 0);
        check("rst_alu_side", {alu_a, alu_op}, 0);
        cyc(); rst_n = 1'b1;
        repeat (3) cyc();

        // Single ADD from requester 0, ALU idle: accept T, response T+4
        rsp_ready = 2'b11; op_a[0] = sc(3); op_b[0] = sc(4); funct[0] = GA_FUNCT_ADD; req_valid = 2'b01;
        smp(); check("t1_accept", req_ready, 2'b01);
        cyc(); req_valid = '0;
        smp(); check("t1_issue", {alu_valid, busy}, 2'b11); check("t1_opa", alu_a, sc(3));
        cyc(); smp(); check("t1_wait", {alu_valid, rsp_valid}, 0);
        cyc(); smp(); check("t1_no_rsp", rsp_valid, 0);
        cyc(); smp(); check("t1_rsp", rsp_valid, 2'b01); check("t1_result", rsp_result, sc(7));
        check("t1_err", rsp_err, GA_ARB_ERR_NONE);
        cyc(); smp(); check("t1_idle", busy, 0);

        // Both requesters streaming MUL: grants alternate starting at 1
        cyc();
        op_a[0] = sc(2);  op_b[0] = sc(5); funct[0] = GA_FUNCT_MUL;
        op_a[1] = sc(-3); op_b[1] = sc(7); funct[1] = GA_FUNCT_MUL;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            int w;
            logic gi;
            w = 0;
            smp();
            while (req_ready == 0 && w < 12) begin cyc(); smp(); w++; end
            check("t2_grant", req_ready, (g % 2 == 0) ? 2'b10 : 2'b01);
            gi = req_ready[1];
            cyc();
            op_a[gi].scalar = op_a[gi].scalar + 16'sd1;
        end
        req_valid = '0;
        repeat (5) cyc();

        // Unsupported funct from requester 1: immediate ILLEGAL response
        funct[1] = ga_funct_e'(4'hF); op_a[1] = sc(9); req_valid = 2'b10; rsp_ready = 2'b10;
        smp(); check("t3_accept", req_ready, 2'b10);
        cyc(); req_valid = '0;
        smp(); check("t3_rsp", rsp_valid, 2'b10); check("t3_no_alu", alu_valid, 0);
        check("t3_err", rsp_err, GA_ARB_ERR_ILLEGAL); check("t3_result", rsp_result, 0);
        cyc();
        // Pointer advanced to 0; requester 1 withdraws after losing
        funct[0] = GA_FUNCT_ADD; op_a[0] = sc(1); op_b[0] = sc(1);
        funct[1] = GA_FUNCT_ADD; op_a[1] = sc(5); rsp_ready = 2'b11; req_valid = 2'b11;
        smp(); check("t3_rr_next", req_ready, 2'b01);
        cyc(); req_valid = '0;
        repeat (5) cyc();

        // Slow ALU: timeout after 4 WAIT cycles, then its stale DONE lands in ISSUE
        alu_lat = 6;
        op_a[0] = sc(1); op_b[0] = sc(2); funct[0] = GA_FUNCT_ADD; req_valid = 2'b01; rsp_ready = 2'b01;
        smp(); check("t4_accept", req_ready, 2'b01);
        cyc(); req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            smp(); check("t4_no_rsp", rsp_valid, 0);
            cyc();
        end
        smp(); check("t4_rsp", rsp_valid, 2'b01); check("t4_err", rsp_err, GA_ARB_ERR_TIMEOUT);
        check("t4_result", rsp_result, 0);
        alu_lat = 1;
        cyc();
        op_a[0] = sc(10); op_b[0] = sc(3); funct[0] = GA_FUNCT_SUB; req_valid = 2'b01;
        smp(); check("t5_accept", req_ready, 2'b01);
        cyc(); req_valid = '0;
        smp(); check("t5_issue", alu_valid, 1);
        cyc(); smp(); check("t5_stale_ignored", alu_valid, 1);
        cyc(); smp(); check("t5_wait", {alu_valid, busy}, 2'b01);
        cyc(); smp();
        cyc(); smp(); check("t5_rsp", rsp_valid, 2'b01); check("t5_result", rsp_result, sc(7));
        repeat (3) cyc();

        // Response withheld 10 cycles (only the non-granted ready bit high)
        rsp_ready = 2'b01;
        op_a[1] = sc(6); op_b[1] = sc(7); funct[1] = GA_FUNCT_MUL;
        op_a[0] = '0;    op_b[0] = sc(1); funct[0] = GA_FUNCT_NORM;
        req_valid = 2'b11;
        smp(); check("t6_accept", req_ready, 2'b10);
        cyc(); req_valid = 2'b01;
        repeat (3) cyc();
        smp(); check("t6_rsp", rsp_valid, 2'b10); check("t6_result", rsp_result, sc(42));
        for (int k = 0; k < 10; k++) begin
            cyc(); smp();
            check("t6_hold", {rsp_valid, rsp_result, rsp_err, req_ready},
                  {2'b10, sc(42), GA_ARB_ERR_NONE, 2'b00});
        end
        cyc(); rsp_ready = 2'b11;
        begin
            int w;
            w = 0;
            cyc(); smp();
            while (req_ready == 0 && w < 12) begin cyc(); smp(); w++; end
            check("t6_next_grant", req_ready, 2'b01);
        end
        cyc(); req_valid = '0;
        repeat (5) cyc();

        // Reset pulsed while in WAIT: outputs clear at once, next op completes
        op_a[1] = sc(8); op_b[1] = sc(8); funct[1] = GA_FUNCT_ADD; req_valid = 2'b10;
        smp(); check("t7_accept", req_ready, 2'b10);
        cyc(); req_valid = '0;
        cyc(); smp();
        #1 rst_n = 1'b0;
        #1 check("t7_rst_async", {busy, alu_valid, rsp_valid, req_ready, alu_a, rsp_err}, 0);
        sb.delete();
        cyc(); cyc(); rst_n = 1'b1;
        repeat (2) cyc();
        op_a[0] = sc(20); op_b[0] = sc(22); funct[0] = GA_FUNCT_ADD;
        op_a[1] = sc(1);  op_b[1] = sc(1);  funct[1] = GA_FUNCT_ADD;
        req_valid = 2'b11;
        smp(); check("t7_rr_reset", req_ready, 2'b01);
        cyc(); req_valid = '0;
        repeat (3) cyc();
        smp(); check("t7_rsp", rsp_valid, 2'b01); check("t7_result", rsp_result, sc(42));
        repeat (4) cyc();
        smp(); check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
